// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types for the memory arbiter: the 2-bit FSM state encoding,
//   the memory-owner enum (I=0, D=1), bus widths and the block-base helper.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_I_FILL  = 2'd1,
        ST_D_FILL  = 2'd2,
        ST_D_WRITE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Byte address of the block holding 'addr'. A block spans
    // 2*blk_words bytes, so those low address bits are cleared.
    function automatic logic [ADDR_W-1:0] blk_base(
        input logic [ADDR_W-1:0] addr,
        input int unsigned       blk_words
    );
        logic [ADDR_W-1:0] mask;
        mask = ADDR_W'(2 * blk_words - 1);
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/mem_arbiter_counter.sv
// arb_counter
//   Width-parameterised up-counter with synchronous clear and enable.
//   Saturates at MAX_VAL; o_term flags that the count equals MAX_VAL.
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset
//   i_clr   synchronous clear to zero
//   i_en    count enable
//   o_cnt   current count
//   o_term  count == MAX_VAL
module arb_counter #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned MAX_VAL = 7
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_term
);

    logic [WIDTH-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_term = (r_cnt == WIDTH'(MAX_VAL));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_term) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates one main-memory port between a fetch-side block filler and
//   a data-side requester (block fill or single-word write-through).
//   One owner at a time; on simultaneous requests D wins unless D owned
//   the previous transaction, so fetch cannot be starved.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_req, i_addr            fetch block-fill request and miss address
//   d_req, d_wr, d_addr,
//   d_wdata                  data-side request, write select, address, data
//   i_fill_vld, d_fill_vld   fill word present for fetch / data side
//   fill_idx, fill_data      word index within block and the word itself
//   i_done, d_done           single-cycle completion pulses
//   mem_en, mem_wr,
//   mem_addr, mem_wdata      memory request strobe, write select, byte addr, data
//   mem_data_out, mem_valid  memory read data and its valid
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT   = 4,
    parameter int unsigned BLK_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_req,
    input  logic [15:0]                  i_addr,
    input  logic                         d_req,
    input  logic                         d_wr,
    input  logic [15:0]                  d_addr,
    input  logic [15:0]                  d_wdata,
    output logic                         i_fill_vld,
    output logic                         d_fill_vld,
    output logic [$clog2(BLK_WORDS)-1:0] fill_idx,
    output logic [15:0]                  fill_data,
    output logic                         i_done,
    output logic                         d_done,
    output logic                         mem_en,
    output logic                         mem_wr,
    output logic [15:0]                  mem_addr,
    output logic [15:0]                  mem_wdata,
    input  logic [15:0]                  mem_data_out,
    input  logic                         mem_valid
);

    localparam int unsigned IDX_W = $clog2(BLK_WORDS);

    if (BLK_WORDS < 2 || (BLK_WORDS & (BLK_WORDS - 1)) != 0 || MEM_LAT < 1) begin : g_bad_param
        $error("mem_arbiter: BLK_WORDS must be a power of two >= 2 and MEM_LAT >= 1");
    end

    arb_state_t        r_state;
    owner_t            r_last_owner;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_issue_done;

    logic             w_in_fill;
    logic             w_idle;
    logic             w_issue_en;
    logic             w_rcv_en;
    logic             w_last_rcv;
    logic             w_issue_term;
    logic             w_rcv_term;
    logic [IDX_W-1:0] w_issue_cnt;
    logic [IDX_W-1:0] w_rcv_cnt;
    logic             w_grant_d;
    logic             w_grant_i;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_in_fill  = (r_state == ST_I_FILL) || (r_state == ST_D_FILL);
    // Issue stops once the saturated counter's last address has gone out.
    assign w_issue_en = w_in_fill && !r_issue_done;
    // Responses outside a fill are ignored entirely.
    assign w_rcv_en   = w_in_fill && mem_valid;
    assign w_last_rcv = w_rcv_en && w_rcv_term;

    // D has priority, except that after a D transaction a waiting I wins.
    assign w_grant_d = d_req && !(i_req && (r_last_owner == OWN_D));
    assign w_grant_i = i_req && !w_grant_d;

    arb_counter #(
        .WIDTH   (IDX_W),
        .MAX_VAL (BLK_WORDS - 1)
    ) u_issue_cnt (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_clr  (w_idle),
        .i_en   (w_issue_en),
        .o_cnt  (w_issue_cnt),
        .o_term (w_issue_term)
    );

    arb_counter #(
        .WIDTH   (IDX_W),
        .MAX_VAL (BLK_WORDS - 1)
    ) u_rcv_cnt (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_clr  (w_idle),
        .i_en   (w_rcv_en),
        .o_cnt  (w_rcv_cnt),
        .o_term (w_rcv_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_owner <= OWN_I;
            r_base       <= '0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_issue_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_issue_done <= 1'b0;
                    if (w_grant_d) begin
                        r_last_owner <= OWN_D;
                        if (d_wr) begin
                            r_state <= ST_D_WRITE;
                            r_waddr <= d_addr;
                            r_wdata <= d_wdata;
                        end else begin
                            r_state <= ST_D_FILL;
                            r_base  <= blk_base(d_addr, BLK_WORDS);
                        end
                    end else if (w_grant_i) begin
                        r_last_owner <= OWN_I;
                        r_state      <= ST_I_FILL;
                        r_base       <= blk_base(i_addr, BLK_WORDS);
                    end
                end
                ST_I_FILL, ST_D_FILL: begin
                    if (w_issue_en && w_issue_term) begin
                        r_issue_done <= 1'b1;
                    end
                    if (w_last_rcv) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_D_WRITE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        i_fill_vld = 1'b0;
        d_fill_vld = 1'b0;
        fill_idx   = '0;
        fill_data  = '0;
        i_done     = 1'b0;
        d_done     = 1'b0;

        if (w_issue_en) begin
            mem_en   = 1'b1;
            mem_addr = r_base + ADDR_W'({w_issue_cnt, 1'b0});
        end

        if (r_state == ST_D_WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = r_waddr;
            mem_wdata = r_wdata;
            d_done    = 1'b1;
        end

        if (w_rcv_en) begin
            fill_idx  = w_rcv_cnt;
            fill_data = mem_data_out;
            if (r_state == ST_I_FILL) begin
                i_fill_vld = 1'b1;
                i_done     = w_last_rcv;
            end else begin
                d_fill_vld = 1'b1;
                d_done     = w_last_rcv;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter: a vector table of single transactions
//   plus hand-written sequences for arbitration, reset and spurious data.
//   Includes a fixed-latency memory model answering reads.
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;
    localparam int BW      = 8;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        i_fill_vld;
    logic        d_fill_vld;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data;
    logic        i_done;
    logic        d_done;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_data_out;
    logic        mem_valid;
    logic        spur;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(
        .MEM_LAT   (MEM_LAT),
        .BLK_WORDS (BW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .d_req        (d_req),
        .d_wr         (d_wr),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .i_fill_vld   (i_fill_vld),
        .d_fill_vld   (d_fill_vld),
        .fill_idx     (fill_idx),
        .fill_data    (fill_data),
        .i_done       (i_done),
        .d_done       (d_done),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_data_out (mem_data_out),
        .mem_valid    (mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: a read issued in cycle c returns in cycle c+MEM_LAT.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    logic        pv [MEM_LAT];
    logic [15:0] pa [MEM_LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MEM_LAT; k++) pv[k] <= 1'b0;
        end else begin
            pv[0] <= mem_en && !mem_wr;
            pa[0] <= mem_addr;
            for (int k = 1; k < MEM_LAT; k++) begin
                pv[k] <= pv[k-1];
                pa[k] <= pa[k-1];
            end
        end
    end

    assign mem_valid    = pv[MEM_LAT-1] | spur;
    assign mem_data_out = spur ? 16'hDEAD :
                          (pv[MEM_LAT-1] ? mem_word(pa[MEM_LAT-1]) : 16'h0000);

    logic [56:0] outs;
    assign outs = {i_fill_vld, d_fill_vld, fill_idx, fill_data, i_done, d_done,
                   mem_en, mem_wr, mem_addr, mem_wdata};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          drop_at;   // cycle at which req is dropped early (0 = hold)
        logic [15:0] exp_base;
        int          exp_done;  // cycle of done, counted from req edge
    } vec_t;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; spur = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int  c;
        int  first;
        int  nis;
        int  nrcv;
        bit  done;
        logic own_vld, oth_vld, own_done;
        @(negedge clk);
        if (v.is_d) begin
            d_req = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        c = 0; first = -1; nis = 0; nrcv = 0; done = 1'b0;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
            own_vld  = v.is_d ? d_fill_vld : i_fill_vld;
            oth_vld  = v.is_d ? i_fill_vld : d_fill_vld;
            own_done = v.is_d ? d_done : i_done;
            chk("other_side_vld", oth_vld, 0);
            if (v.wr) begin
                chk("wr_cycle", c, v.exp_done);
                chk("wr_en", {mem_en, mem_wr}, 2'b11);
                chk("wr_addr", mem_addr, v.exp_base);
                chk("wr_data", mem_wdata, v.wdata);
                chk("wr_done", d_done, 1);
                chk("wr_no_fill", {i_fill_vld, d_fill_vld}, 0);
                done = 1'b1;
            end else begin
                if (mem_en) begin
                    if (first < 0) first = c;
                    chk("issue_wr", mem_wr, 0);
                    chk("issue_addr", mem_addr, v.exp_base + 16'(2 * nis));
                    nis++;
                end
                if (own_vld) begin
                    chk("fill_idx", fill_idx, nrcv);
                    chk("fill_data", fill_data, mem_word(v.exp_base + 16'(2 * nrcv)));
                    nrcv++;
                end
                if (own_done) begin
                    chk("first_issue", first, 1);
                    chk("done_cycle", c, v.exp_done);
                    chk("n_issue", nis, BW);
                    chk("n_rcv", nrcv, BW);
                    done = 1'b1;
                end
            end
            if (v.drop_at == c) begin
                if (v.is_d) d_req = 1'b0; else i_req = 1'b0;
            end
        end
        if (v.is_d) d_req = 1'b0; else i_req = 1'b0;
        d_wr = 1'b0;
        chk("txn_completed", done, 1);
    endtask

    vec_t vecs [6];
    int   tdd, tid, tif, nd, ni, ni_early, bad, nev;
    bit   seen;
    int   ev_own [4];
    int   ev_t   [4];
    int   exp_own [4];
    int   exp_t   [4];

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{is_d: 0, wr: 0, addr: 16'h0120, wdata: 16'h0000, drop_at: 0, exp_base: 16'h0120, exp_done: 12};
        vecs[1] = '{is_d: 0, wr: 0, addr: 16'h012F, wdata: 16'h0000, drop_at: 0, exp_base: 16'h0120, exp_done: 12};
        vecs[2] = '{is_d: 1, wr: 0, addr: 16'h8047, wdata: 16'h0000, drop_at: 0, exp_base: 16'h8040, exp_done: 12};
        vecs[3] = '{is_d: 1, wr: 1, addr: 16'h4002, wdata: 16'hBEEF, drop_at: 0, exp_base: 16'h4002, exp_done: 1};
        vecs[4] = '{is_d: 0, wr: 0, addr: 16'hFFF5, wdata: 16'h0000, drop_at: 3, exp_base: 16'hFFF0, exp_done: 12};
        vecs[5] = '{is_d: 1, wr: 0, addr: 16'h3AB0, wdata: 16'h0000, drop_at: 5, exp_base: 16'h3AB0, exp_done: 12};

        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; spur = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", outs, 0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            @(negedge clk);
            chk("idle_between", outs, 0);
        end

        // Simultaneous fill requests right after reset: D first, then I.
        do_reset();
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0120; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2000;
        tdd = -1; tid = -1; tif = -1; nd = 0; ni = 0; ni_early = 0;
        for (int c = 1; c <= 60 && tid < 0; c++) begin
            @(negedge clk);
            if (d_fill_vld) nd++;
            if (i_fill_vld) begin
                ni++;
                if (tdd < 0) ni_early++;
            end
            if (mem_en && tdd >= 0 && tif < 0) tif = c;
            if (d_done) begin tdd = c; d_req = 1'b0; end
            if (i_done) begin tid = c; i_req = 1'b0; end
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("both_d_done", tdd, 12);
        chk("both_i_first_issue", tif, 14);
        chk("both_i_done", tid, 25);
        chk("both_d_words", nd, BW);
        chk("both_i_words", ni, BW);
        chk("both_i_before_d", ni_early, 0);

        // Reset while an I fill has received three words.
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0120; seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (i_fill_vld && fill_idx == 3'd2) seen = 1'b1;
        end
        chk("rst_mid_reached", seen, 1);
        rst = 1'b1; i_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs_zero", outs, 0);
        rst = 1'b0; bad = 0;
        repeat (16) begin
            @(negedge clk);
            if (i_done || i_fill_vld || d_fill_vld || mem_en) bad++;
        end
        chk("rst_mid_quiet", bad, 0);
        run_vec(vecs[0]);

        // Continuous writes with fetch held: ownership alternates D, I, D, I.
        exp_own = '{1, 0, 1, 0};
        exp_t   = '{1, 14, 16, 29};
        for (int k = 0; k < 4; k++) begin ev_own[k] = -1; ev_t[k] = -1; end
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0300; d_req = 1'b1; d_wr = 1'b1;
        d_addr = 16'h4010; d_wdata = 16'h1000;
        nev = 0; ni = 0; nd = 0;
        for (int c = 1; c <= 80 && ni < 2; c++) begin
            @(negedge clk);
            if (d_done) begin
                chk("alt_wdata", mem_wdata, 16'h1000 + 16'(nd));
                if (nev < 4) begin ev_own[nev] = 1; ev_t[nev] = c; end
                nev++; nd++;
                d_wdata = 16'h1000 + 16'(nd);
            end
            if (i_done) begin
                if (nev < 4) begin ev_own[nev] = 0; ev_t[nev] = c; end
                nev++; ni++;
            end
        end
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        chk("alt_events", nev, 4);
        for (int k = 0; k < 4; k++) begin
            chk("alt_owner", ev_own[k], exp_own[k]);
            chk("alt_time", ev_t[k], exp_t[k]);
        end

        // Spurious mem_valid while idle.
        repeat (2) @(negedge clk);
        spur = 1'b1;
        #1;
        chk("spur_no_fill", {i_fill_vld, d_fill_vld, i_done, d_done, mem_en}, 0);
        #2 spur = 1'b0;
        @(negedge clk);
        chk("spur_idle_after", outs, 0);
        run_vec(vecs[3]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 4: main-memory read latency in cycles from address issue to mem_valid.
REQ-002 Parameter BLK_WORDS, default 8: 16-bit words per cache block; must be a power of two.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 i_req  in  1  fetch-side block-fill request; held high until i_done.
REQ-006 i_addr  in  16  fetch miss address; low log2(BLK_WORDS)+1 bits ignored.
REQ-007 d_req  in  1  data-side request; held high until d_done.
REQ-008 d_wr  in  1  1 = single-word write-through, 0 = block fill.
REQ-009 d_addr  in  16  data address; word-aligned for writes, block-aligned for fills.
REQ-010 d_wdata  in  16  write data, sampled at grant.
REQ-011 i_fill_vld / d_fill_vld  out  1 each  one fill word present this cycle.
REQ-012 fill_idx  out  log2(BLK_WORDS)  word index within block of the current fill word.
REQ-013 fill_data  out  16  fill word, forwarded from mem_data_out.
REQ-014 i_done / d_done  out  1 each  single-cycle completion pulse.
REQ-015 mem_en, mem_wr  out  1 each  memory strobe and write select.
REQ-016 mem_addr  out  16  memory byte address.
REQ-017 mem_wdata  out  16  memory write data.
REQ-018 mem_data_out  in  16  memory read data.
REQ-019 mem_valid  in  1  memory read data valid.

Function
REQ-020 FSM states: IDLE, I_FILL, D_FILL, D_WRITE; exactly one owner of memory at a time.
REQ-021 IDLE arbitration with i_req and d_req both high: grant D, unless last_owner==D and i_req high, then grant I; last_owner flop resets to I.
REQ-022 Single requester: granted the cycle after its req is seen in IDLE; no grant is issued while an owner is active.
REQ-023 Fill: issue BLK_WORDS addresses on consecutive cycles, mem_en=1, mem_wr=0, mem_addr = block base + 2*issue_cnt; issue_cnt 0..BLK_WORDS-1 and saturates.
REQ-024 Each mem_valid during a fill: assert the owner's *_fill_vld, fill_idx = rcv_cnt, fill_data = mem_data_out; then increment rcv_cnt.
REQ-025 On the cycle the last word is received (rcv_cnt==BLK_WORDS-1 with mem_valid): pulse the owner's done the same cycle; next state IDLE.
REQ-026 Fill latency: done asserted MEM_LAT+BLK_WORDS-1 cycles after the first issue (11 cycles at defaults).
REQ-027 D_WRITE: one cycle with mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata; d_done pulses that cycle; next state IDLE.
REQ-028 mem_valid while in IDLE or D_WRITE: ignored; no fill_vld asserted.
REQ-029 Requester deasserting req mid-transaction: no effect; transaction completes.
REQ-030 Outside active issue cycles: mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
REQ-031 Back-to-back requests: a new grant is possible the cycle after done; minimum one IDLE cycle between transactions.

Reset
REQ-032 While rst=1 at a clock edge: state=IDLE, issue_cnt=rcv_cnt=0, last_owner=I, all outputs 0.
REQ-033 Reset mid-transaction: the transaction is abandoned with no done pulse; memory is reset on the same rst, so there are no stale responses.

Structure
REQ-034 Shared package holds the state encoding (2-bit) and the owner enum (I=0, D=1); MEM_LAT and BLK_WORDS are module parameters.
REQ-035 One sub-module, arb_counter: a width-parameterized counter with clear/enable and terminal flag, instantiated for issue_cnt and rcv_cnt.

Verification
REQ-036 i_req only, i_addr=0x0120: addresses 0x0120..0x012E issued; 8 i_fill_vld with fill_idx 0..7; i_done 11 cycles after the first issue.
REQ-037 i_req and d_req (fill) rise together after reset: D served first, I granted the cycle after d_done+1 IDLE cycle, because last_owner=D.
REQ-038 d_req with d_wr=1, d_addr=0x4002, d_wdata=0xBEEF: one write cycle; d_done in the same cycle; no fill_vld.
REQ-039 rst asserted at rcv_cnt=3 of an I fill: all outputs 0 next cycle; no i_done; a new i_req is served cleanly.
REQ-040 Continuous d_req writes with i_req held: I is granted on alternate transactions, so fetch is never starved.
REQ-041 Spurious mem_valid injected in IDLE: no fill_vld asserted and no state change.
